// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequences AES-128 key expansion, banks the round keys and serves them by index
module aes_key_sched_ctrl #(
    parameter int DATA_W    = 128,
    parameter int KEY_L     = 128,
    parameter int NO_ROUNDS = 10,
    parameter int TIMEOUT   = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_load,
    input  logic [KEY_L-1:0]              key_in,
    output logic                          key_busy,
    output logic                          key_ready,
    output logic                          key_err,
    output logic                          ks_valid_in,
    output logic [KEY_L-1:0]              ks_cipher_key,
    input  logic [NO_ROUNDS*DATA_W-1:0]   ks_W,
    input  logic [NO_ROUNDS-1:0]          ks_valid_out,
    input  logic                          rk_req,
    input  logic [3:0]                    rk_idx,
    output logic                          rk_valid,
    output logic                          rk_oob,
    output logic [DATA_W-1:0]             rk_data
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] MAX_IDX  = 4'(NO_ROUNDS);

    state_t                      state_q;
    logic [7:0]                  cnt_q;
    logic [KEY_L-1:0]            key_q;
    logic [NO_ROUNDS*DATA_W-1:0] bank_q;
    logic                        busy_q, ready_q, err_q, launch_q;
    logic                        rk_valid_q, rk_oob_q;
    logic [DATA_W-1:0]           rk_data_q, rk_data_d;
    logic [DATA_W-1:0]           rk_arr [NO_ROUNDS+1];
    logic                        rk_in_range, rd_fire, done;

    // Entry 0 is the cipher key itself; round 1 sits in the top slice of the captured bank
    assign rk_arr[0] = DATA_W'(key_q);
    for (genvar r = 1; r <= NO_ROUNDS; r++) begin : g_rk
        assign rk_arr[r] = bank_q[(NO_ROUNDS-r+1)*DATA_W-1 -: DATA_W];
    end

    assign done        = ks_valid_out[NO_ROUNDS-1];
    assign rk_in_range = rk_idx <= MAX_IDX;
    assign rd_fire     = (state_q == READY) && rk_req;

    // Read mux: out-of-range indices return zero
    always_comb rk_data_d = rk_in_range ? rk_arr[rk_idx] : '0;

    // Control FSM with registered status/launch outputs and the 1-cycle read port
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            key_q      <= '0;
            bank_q     <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            launch_q   <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_oob_q   <= 1'b0;
            rk_data_q  <= '0;
        end else begin
            launch_q   <= 1'b0;
            rk_valid_q <= rd_fire;
            rk_oob_q   <= rd_fire && !rk_in_range;
            if (rd_fire) rk_data_q <= rk_data_d;
            case (state_q)
                IDLE, READY: if (key_load) begin
                    state_q  <= EXPAND;
                    key_q    <= key_in;
                    cnt_q    <= '0;
                    err_q    <= 1'b0;
                    launch_q <= 1'b1;
                    busy_q   <= 1'b1;
                    ready_q  <= 1'b0;
                end
                EXPAND: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (done) begin
                        state_q <= READY;
                        bank_q  <= ks_W;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign key_busy      = busy_q;
    assign key_ready     = ready_q;
    assign key_err       = err_q;
    assign ks_valid_in   = launch_q;
    assign ks_cipher_key = key_q;
    assign rk_valid      = rk_valid_q;
    assign rk_oob        = rk_oob_q;
    assign rk_data       = rk_data_q;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed scoreboard bench for the AES key-schedule controller
module tb_aes_key_sched_ctrl;
    localparam int DW = 128;
    localparam int NR = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             key_load = 1'b0;
    logic [DW-1:0]    key_in = '0;
    logic             key_busy, key_ready, key_err, ks_valid_in;
    logic [DW-1:0]    ks_cipher_key;
    logic [NR*DW-1:0] w_model = '0;
    logic [NR-1:0]    ks_valid_out;
    logic             rk_req = 1'b0;
    logic [3:0]       rk_idx = '0;
    logic             rk_valid, rk_oob;
    logic [DW-1:0]    rk_data;

    aes_key_sched_ctrl dut (
        .clk(clk), .reset(reset), .key_load(key_load), .key_in(key_in),
        .key_busy(key_busy), .key_ready(key_ready), .key_err(key_err),
        .ks_valid_in(ks_valid_in), .ks_cipher_key(ks_cipher_key),
        .ks_W(w_model), .ks_valid_out(ks_valid_out),
        .rk_req(rk_req), .rk_idx(rk_idx),
        .rk_valid(rk_valid), .rk_oob(rk_oob), .rk_data(rk_data)
    );

    always #5 clk = ~clk;

    // Pipeline model: done appears 10 cycles after the launch pulse unless masked
    logic [NR-1:0] vpipe = '0;
    logic          pipe_mask = 1'b0;
    always @(posedge clk) vpipe <= {vpipe[NR-2:0], ks_valid_in};
    assign ks_valid_out = pipe_mask ? '0 : vpipe;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          oob;
        int            at;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] key1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [DW-1:0] key2 = 128'h000102030405060708090a0b0c0d0e0f;
    logic [DW-1:0] key3 = 128'hffeeddccbbaa99887766554433221100;
    logic [DW-1:0] tab1 [1:NR];
    logic [DW-1:0] tab2 [1:NR];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every read response must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rk_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL rd_unexpected: got rk_valid=1 data=%h expected no response", rk_data);
            end else begin
                e = sb.pop_front();
                chk("rd_data", rk_data, e.data);
                chk("rd_oob", rk_oob, e.oob);
                chk("rd_cycle", cyc, e.at);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [DW-1:0] d, input logic o);
        rk_req = 1'b1;
        rk_idx = idx;
        sb.push_back('{d, o, cyc + 1});
        tick();
        rk_req = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, key_busy, 0);
        chk({name, "_ready"}, key_ready, 0);
        chk({name, "_err"}, key_err, 0);
        chk({name, "_launch"}, ks_valid_in, 0);
        chk({name, "_ckey"}, ks_cipher_key, 0);
        chk({name, "_rkv"}, rk_valid, 0);
        chk({name, "_oob"}, rk_oob, 0);
        chk({name, "_rkd"}, rk_data, 0);
    endtask

    // Load a key and check launch, busy window and ready timing; optionally try a stray load mid-expansion
    task automatic load_expand(input logic [DW-1:0] k, input bit inject);
        key_in = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        chk("launch", {ks_valid_in, key_busy, key_ready}, 3'b110);
        chk("ks_key", ks_cipher_key, k);
        chk("err_clr", key_err, 0);
        for (int i = 2; i <= 11; i++) begin
            tick();
            key_load = 1'b0;
            chk("expand", {ks_valid_in, key_busy, key_ready}, 3'b010);
            chk("ks_key_hold", ks_cipher_key, k);
            if (inject && i == 3) begin
                key_in = key3;
                key_load = 1'b1;
            end
        end
        tick();
        chk("ready", {ks_valid_in, key_busy, key_ready}, 3'b001);
    endtask

    function automatic logic [NR*DW-1:0] pack(input logic [DW-1:0] t [1:NR]);
        logic [NR*DW-1:0] w = '0;
        for (int r = 1; r <= NR; r++) w = {w[(NR-1)*DW-1:0], t[r]};
        return w;
    endfunction

    initial begin
        tab1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        tab1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        tab1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        tab1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        tab1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        tab1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        tab1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        tab1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        tab1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        tab1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int r = 1; r <= NR; r++) tab2[r] = {4{32'h11111111 * 32'(r)}};
        w_model = pack(tab1);
        repeat (2) tick();
        chk_zero("rst");
        reset = 1'b0;
        tick();
        // Test 1: first expansion
        load_expand(key1, 1'b0);
        // Test 2: in-range reads
        rd(4'd0, key1, 1'b0);
        rd(4'd1, tab1[1], 1'b0);
        rd(4'd10, tab1[10], 1'b0);
        rd(4'd5, tab1[5], 1'b0);
        // Test 3: out-of-range reads
        rd(4'd11, '0, 1'b1);
        rd(4'd15, '0, 1'b1);
        tick();
        // Test 4: stray load during expansion is ignored
        w_model = pack(tab2);
        load_expand(key2, 1'b1);
        rd(4'd0, key2, 1'b0);
        rd(4'd3, tab2[3], 1'b0);
        // Load and read on the same edge: old bank answers, ready drops
        key_in = key3;
        key_load = 1'b1;
        rk_req = 1'b1;
        rk_idx = 4'd1;
        sb.push_back('{tab2[1], 1'b0, cyc + 1});
        tick();
        key_load = 1'b0;
        chk("ld_rd_state", {ks_valid_in, key_busy, key_ready}, 3'b110);
        chk("ld_rd_key", ks_cipher_key, key3);
        rk_idx = 4'd2;
        tick();
        rk_req = 1'b0;
        chk("blocked_rd_valid", rk_valid, 0);
        chk("blocked_rd_hold", rk_data, tab2[1]);
        repeat (10) tick();
        chk("key3_ready", key_ready, 1);
        rd(4'd0, key3, 1'b0);
        // Test 5: expansion timeout
        pipe_mask = 1'b1;
        w_model = pack(tab1);
        key_in = key1;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        repeat (14) tick();
        chk("to_last", {key_busy, key_ready, key_err}, 3'b100);
        tick();
        chk("to_abort", {key_busy, key_ready, key_err}, 3'b001);
        rk_req = 1'b1;
        rk_idx = 4'd1;
        tick();
        rk_req = 1'b0;
        chk("to_sticky", key_err, 1);
        pipe_mask = 1'b0;
        load_expand(key1, 1'b0);
        rd(4'd10, tab1[10], 1'b0);
        // Test 6: reset in the middle of an expansion
        key_in = key2;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk_zero("rst_mid");
        reset = 1'b0;
        repeat (6) tick();
        rk_req = 1'b1;
        rk_idx = 4'd0;
        tick();
        rk_req = 1'b0;
        chk("late_done", {key_busy, key_ready, key_err}, 3'b000);
        tick();
        chk("late_done2", {key_busy, key_ready}, 2'b00);
        repeat (2) tick();
        chk("sb_drain", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
